// File: rtl/mic_spi_capture_if.sv
`default_nettype none
// ============================================================================
// mic_spi_capture_if : ADC SPI pins and captured-sample outputs. Rev 1.0
// ============================================================================
interface mic_spi_capture_if;
  logic        MISO;
  logic        SCLK;
  logic        SS;
  logic [11:0] sample_12bit;
  logic [7:0]  digital_8bit;
  logic        sample_valid;
  logic        zero_err;

  modport master (
    input  MISO,
    output SCLK, SS, sample_12bit, digital_8bit, sample_valid, zero_err
  );

  modport slave (
    output MISO,
    input  SCLK, SS, sample_12bit, digital_8bit, sample_valid, zero_err
  );
endinterface
`default_nettype wire

// File: rtl/mic_spi_capture.sv
`default_nettype none
// ============================================================================
// mic_spi_capture : SPI master reading 16-bit mic ADC frames into 12/8-bit words. Rev 1.0
// ============================================================================
module mic_spi_capture #(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 200,
  parameter int ZERO_BITS     = 4,
  parameter int DATA_BITS     = 12
) (
  input  wire logic         clk,
  input  wire logic         btnC,
  mic_spi_capture_if.master bus
);
  localparam int c_FRAME_BITS = ZERO_BITS + DATA_BITS;
  localparam int c_DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int c_PER_W      = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int c_CNT_W      = $clog2(c_FRAME_BITS + 1);

  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
  localparam logic [c_PER_W-1:0] c_PER_LAST = c_PER_W'(SAMPLE_PERIOD - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_FRAME_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [c_PER_W-1:0]      r_period;
  logic [c_DIV_W-1:0]      r_div;
  logic [c_CNT_W-1:0]      r_bitcnt;
  logic [c_FRAME_BITS-1:0] r_shift;
  logic                    r_ss;
  logic                    r_sclk;
  logic [11:0]             r_sample;
  logic [7:0]              r_digital;
  logic                    r_valid;
  logic                    r_zero_err;

  logic w_start;
  logic w_tick;
  logic w_rise;
  logic w_last;

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_tick  = 1'b0;
    w_rise  = 1'b0;
    w_last  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_period == '0) begin
          w_start = 1'b1;
          w_next  = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        w_tick = (r_div == c_DIV_LAST);
        // SCLK low at a terminal count means this toggle is a rising edge
        w_rise = w_tick && !r_sclk;
        w_last = w_rise && (r_bitcnt == c_CNT_LAST);
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (btnC) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (btnC) begin
      r_period   <= '0;
      r_div      <= '0;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_ss       <= 1'b1;
      r_sclk     <= 1'b1;
      r_sample   <= '0;
      r_digital  <= '0;
      r_valid    <= 1'b0;
      r_zero_err <= 1'b0;
    end else begin
      r_valid    <= 1'b0;
      r_zero_err <= 1'b0;
      r_period   <= (r_period == c_PER_LAST) ? '0 : r_period + 1'b1;

      if (w_start) begin
        r_ss     <= 1'b0;
        r_div    <= '0;
        r_bitcnt <= '0;
      end

      if (r_state == S_ACTIVE) begin
        r_div <= w_tick ? '0 : r_div + 1'b1;
        if (w_tick) begin
          r_sclk <= ~r_sclk;
        end
        if (w_rise) begin
          r_shift  <= {r_shift[c_FRAME_BITS-2:0], bus.MISO};
          r_bitcnt <= r_bitcnt + 1'b1;
        end
        if (w_last) begin
          r_ss <= 1'b1;
        end
      end

      if (r_state == S_DONE) begin
        r_sample   <= r_shift[11:0];
        r_digital  <= r_shift[11:4];
        r_valid    <= 1'b1;
        r_zero_err <= |r_shift[c_FRAME_BITS-1:DATA_BITS];
      end

      // A wrap while a frame is in flight would be silently skipped
      assert (r_state == S_IDLE || r_period != '0);
    end
  end

  assign bus.SS           = r_ss;
  assign bus.SCLK         = r_sclk;
  assign bus.sample_12bit = r_sample;
  assign bus.digital_8bit = r_digital;
  assign bus.sample_valid = r_valid;
  assign bus.zero_err     = r_zero_err;

endmodule
`default_nettype wire

// File: tb/tb_mic_spi_capture.sv
`default_nettype none
// ============================================================================
// tb_mic_spi_capture : directed bench with ADC models and a sample scoreboard. Rev 1.0
// ============================================================================
module tb_mic_spi_capture;
  typedef struct {
    logic [11:0] s12;
    logic [7:0]  d8;
    logic        ze;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4 = 1'b1;
  logic rst1 = 1'b1;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  mic_spi_capture_if bus4 ();
  mic_spi_capture_if bus1 ();

  mic_spi_capture #(
    .CLK_DIV(4), .SAMPLE_PERIOD(200), .ZERO_BITS(4), .DATA_BITS(12)
  ) u_dut4 (
    .clk(clk), .btnC(rst4), .bus(bus4)
  );

  mic_spi_capture #(
    .CLK_DIV(1), .SAMPLE_PERIOD(40), .ZERO_BITS(4), .DATA_BITS(12)
  ) u_dut1 (
    .clk(clk), .btnC(rst1), .bus(bus1)
  );

  // ADC models: MSB first, next bit presented after each SCLK rise
  logic [15:0] frame4 = 16'h0;
  logic [15:0] frame1 = 16'h0;
  int          idx4 = 16;
  int          idx1 = 16;
  assign bus4.MISO = (idx4 < 16) ? frame4[4'(15 - idx4)] : 1'b0;
  assign bus1.MISO = (idx1 < 16) ? frame1[4'(15 - idx1)] : 1'b0;
  always @(negedge bus4.SS) idx4 = 0;
  always @(negedge bus1.SS) idx1 = 0;
  always @(posedge bus4.SCLK) if (bus4.SS === 1'b0) idx4++;
  always @(posedge bus1.SCLK) if (bus1.SS === 1'b0) idx1++;

  logic        v_vld [2];
  logic [11:0] v_s12 [2];
  logic [7:0]  v_d8  [2];
  logic        v_ze  [2];
  assign v_vld[0] = bus4.sample_valid;
  assign v_vld[1] = bus1.sample_valid;
  assign v_s12[0] = bus4.sample_12bit;
  assign v_s12[1] = bus1.sample_12bit;
  assign v_d8[0]  = bus4.digital_8bit;
  assign v_d8[1]  = bus1.digital_8bit;
  assign v_ze[0]  = bus4.zero_err;
  assign v_ze[1]  = bus1.zero_err;

  int   cyc = 0;
  logic p_ss4 = 1'b1, p_sclk4 = 1'b1, p_ss1 = 1'b1, p_sclk1 = 1'b1;
  int   falls4[$];
  int   rise4 = 0, low4 = 0, vcyc4 = 0;
  int   fall1 = 0, rise1 = 0, lastr1 = 0, mins1 = 0, maxs1 = 0, vcyc1 = 0;

  always @(negedge clk) begin
    int spc;
    cyc++;
    if (p_ss4 === 1'b1 && bus4.SS === 1'b0) begin
      falls4.push_back(cyc);
      rise4 = 0;
    end
    if (p_ss4 === 1'b0 && p_sclk4 === 1'b0 && bus4.SCLK === 1'b1) rise4++;
    if (p_ss4 === 1'b0 && bus4.SS === 1'b1 && falls4.size() > 0) low4 = cyc - falls4[$];
    if (bus4.sample_valid === 1'b1) vcyc4 = cyc;
    p_ss4   = bus4.SS;
    p_sclk4 = bus4.SCLK;

    if (p_ss1 === 1'b1 && bus1.SS === 1'b0) begin
      fall1 = cyc;
      rise1 = 0;
      mins1 = 1000;
      maxs1 = 0;
    end
    if (p_ss1 === 1'b0 && p_sclk1 === 1'b0 && bus1.SCLK === 1'b1) begin
      if (rise1 > 0) begin
        spc = cyc - lastr1;
        if (spc < mins1) mins1 = spc;
        if (spc > maxs1) maxs1 = spc;
      end
      lastr1 = cyc;
      rise1++;
    end
    if (bus1.sample_valid === 1'b1) vcyc1 = cyc;
    p_ss1   = bus1.SS;
    p_sclk1 = bus1.SCLK;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] f);
    exp_t e;
    e.s12 = f[11:0];
    e.d8  = f[11:4];
    e.ze  = |f[15:12];
    sb.push_back(e);
  endtask

  task automatic expect_sample(input int d, input int bound, input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (v_vld[d] !== 1'b1 && n < bound) begin
      step();
      n++;
    end
    chk({tag, "_valid_seen"}, 32'(v_vld[d]), 32'd1);
    if (v_vld[d] === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_s12"}, 32'(v_s12[d]), 32'(e.s12));
      chk({tag, "_d8"},  32'(v_d8[d]),  32'(e.d8));
      chk({tag, "_zerr"}, 32'(v_ze[d]), 32'(e.ze));
      step();
      chk({tag, "_valid_one_cycle"}, 32'(v_vld[d]), 32'd0);
    end
  endtask

  logic [15:0] pat [3] = '{16'h0555, 16'h7AAA, 16'h0F0F};

  initial begin
    int n;
    repeat (3) step();
    chk("rst_ss",     32'(bus4.SS), 32'd1);
    chk("rst_sclk",   32'(bus4.SCLK), 32'd1);
    chk("rst_d8",     32'(bus4.digital_8bit), 32'd0);
    chk("rst_s12",    32'(bus4.sample_12bit), 32'd0);
    chk("rst_valid",  32'(bus4.sample_valid), 32'd0);
    chk("rst_zerr",   32'(bus4.zero_err), 32'd0);
    chk("rst1_ss",    32'(bus1.SS), 32'd1);

    frame4 = 16'h0ABC;
    push(frame4);
    rst4 = 1'b0;
    expect_sample(0, 300, "f0ABC");
    chk("f0ABC_rises",   32'(rise4), 32'd16);
    chk("f0ABC_ss_low",  32'(low4), 32'd128);
    chk("f0ABC_latency", 32'(vcyc4 - falls4[$]), 32'd129);
    chk("f0ABC_hold_s12", 32'(bus4.sample_12bit), 32'hABC);
    chk("f0ABC_hold_d8",  32'(bus4.digital_8bit), 32'hAB);

    frame4 = 16'h8FFF;
    push(frame4);
    expect_sample(0, 300, "f8FFF");
    chk("f8FFF_d8",        32'(bus4.digital_8bit), 32'hFF);
    chk("f8FFF_zerr_ends", 32'(bus4.zero_err), 32'd0);

    for (int i = 0; i < 3; i++) begin
      frame4 = pat[i];
      push(frame4);
      expect_sample(0, 300, "period");
    end
    chk("period_nfalls", 32'(falls4.size()), 32'd5);
    for (int i = 0; i < 4; i++) begin
      if (falls4.size() > i + 1) chk("period_gap", 32'(falls4[i+1] - falls4[i]), 32'd200);
    end

    frame4 = 16'hFFFF;
    n = 0;
    while (!(falls4.size() == 6 && rise4 == 8) && n < 400) begin
      step();
      n++;
    end
    chk("midrst_reached", 32'(rise4), 32'd8);
    rst4 = 1'b1;
    step();
    chk("midrst_ss",    32'(bus4.SS), 32'd1);
    chk("midrst_sclk",  32'(bus4.SCLK), 32'd1);
    chk("midrst_valid", 32'(bus4.sample_valid), 32'd0);
    chk("midrst_s12",   32'(bus4.sample_12bit), 32'd0);
    chk("midrst_d8",    32'(bus4.digital_8bit), 32'd0);
    frame4 = 16'h0123;
    push(frame4);
    rst4 = 1'b0;
    expect_sample(0, 300, "f0123");
    chk("f0123_d8", 32'(bus4.digital_8bit), 32'h12);

    frame1 = 16'h0FFF;
    push(frame1);
    rst1 = 1'b0;
    expect_sample(1, 100, "div1");
    chk("div1_sclk_min", 32'(mins1), 32'd2);
    chk("div1_sclk_max", 32'(maxs1), 32'd2);
    chk("div1_rises",    32'(rise1), 32'd16);
    chk("div1_latency",  32'(vcyc1 - fall1), 32'd33);
    chk("div1_s12",      32'(bus1.sample_12bit), 32'hFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
